lamp_sequence_player: RTL and testbench

Stimulus controller for the three-lamp sequence detector. It stores a programmable list of lamp codes and plays them onto the detector's one-hot lamp bus, holding each code for a programmable dwell time. During playback it counts the alarm pulses the detector returns, and reports busy/done status to the host.

---
 rtl/lamp_sequence_player.sv | 129 ++++++++++++
 tb/tb_lamp_sequence_player.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_sequence_player.sv
// Plays a stored list of lamp codes onto the detector's one-hot lamp bus,
// holding each for a latched dwell time and counting the alarms that come back.
module lamp_sequence_player #(
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [1:0]               load_code,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     start,
  input  logic                     abort,
  output logic [2:0]               lamps,
  input  logic                     alarm_in,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               alarm_count,
  output logic [$clog2(DEPTH):0]   seq_len
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;

  state_t             state, state_nxt;
  logic [1:0]         mem [DEPTH];
  logic [AW-1:0]      idx, idx_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt, cnt, cnt_nxt;
  logic [2:0]         lamps_nxt;
  logic [7:0]         acnt_nxt;
  logic [AW:0]        len_nxt, len_eff;
  logic               load_fire;
  logic [1:0]         code0;

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      2'd1:    decode = 3'b001;
      2'd2:    decode = 3'b010;
      2'd3:    decode = 3'b100;
      default: decode = 3'b000;
    endcase
  endfunction

  // DEPTH is a power of two, so "full" is exactly the top bit of seq_len.
  assign load_ready = (state == IDLE) && !seq_len[AW];
  assign load_fire  = load_valid && load_ready && !clear;
  assign len_eff    = seq_len + {{AW{1'b0}}, load_fire};
  // A load in the start cycle into an empty buffer lands in entry 0.
  assign code0      = (seq_len == '0) ? load_code : mem[0];
  assign busy       = (state == PLAY);
  assign done       = (state == FINISH);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    dwell_nxt = dwell_q;
    lamps_nxt = lamps;
    acnt_nxt  = alarm_count;
    len_nxt   = len_eff;
    case (state)
      IDLE: begin
        if (clear) begin
          len_nxt = '0;
        end else if (start && len_eff != '0) begin
          state_nxt = PLAY;
          idx_nxt   = '0;
          cnt_nxt   = DWELL_W'(1);
          dwell_nxt = (dwell == '0) ? DWELL_W'(1) : dwell;
          acnt_nxt  = '0;
          lamps_nxt = decode(code0);
        end
      end
      PLAY: begin
        if (abort) begin
          state_nxt = IDLE;
          lamps_nxt = 3'b000;
        end else begin
          if (alarm_in && alarm_count != 8'hff) acnt_nxt = alarm_count + 8'd1;
          if (cnt == dwell_q) begin
            if ({1'b0, idx} == seq_len - (AW+1)'(1)) begin
              lamps_nxt = 3'b000;
              state_nxt = FINISH;
            end else begin
              idx_nxt   = idx + AW'(1);
              cnt_nxt   = DWELL_W'(1);
              lamps_nxt = decode(mem[idx + AW'(1)]);
            end
          end else begin
            cnt_nxt = cnt + DWELL_W'(1);
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        if (alarm_in && alarm_count != 8'hff) acnt_nxt = alarm_count + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      dwell_q     <= '0;
      lamps       <= 3'b000;
      alarm_count <= '0;
      seq_len     <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      dwell_q     <= dwell_nxt;
      lamps       <= lamps_nxt;
      alarm_count <= acnt_nxt;
      seq_len     <= len_nxt;
    end
  end

  // Buffer contents need no reset; seq_len alone says what is valid.
  always_ff @(posedge clk) begin
    if (load_fire) mem[seq_len[AW-1:0]] <= load_code;
  end

endmodule

// File: tb/tb_lamp_sequence_player.sv
// Scoreboard bench for lamp_sequence_player with a small lamp-sequence
// detector model closing the alarm loop.
module tb_lamp_sequence_player;
  localparam int DEPTH = 16, DWELL_W = 8;

  logic clk = 1'b0;
  logic reset, load_valid, clear, start, abort, alarm_in, load_ready, busy, done;
  logic [1:0] load_code;
  logic [DWELL_W-1:0] dwell;
  logic [2:0] lamps;
  logic [7:0] alarm_count;
  logic [4:0] seq_len;

  int total = 0, bad = 0, acnt_exp = 0;

  typedef struct {logic [2:0] lamps; logic busy; logic done;} exp_t;
  exp_t exp_q[$];
  logic [1:0] codes[$];

  logic force_alarm = 1'b0;
  logic [2:0] d1, d2, d3;
  logic dalarm;

  always #5 clk = ~clk;

  lamp_sequence_player #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_code(load_code),
    .load_ready(load_ready), .clear(clear), .dwell(dwell), .start(start),
    .abort(abort), .lamps(lamps), .alarm_in(alarm_in), .busy(busy),
    .done(done), .alarm_count(alarm_count), .seq_len(seq_len)
  );

  // Detector: registered alarm one cycle after lamp 3 follows distinct lamps 1,2.
  always @(posedge clk) begin
    if (lamps == 3'b000) begin
      d1 <= '0; d2 <= '0; d3 <= '0; dalarm <= 1'b0;
    end else if (lamps != d1) begin
      d1 <= lamps; d2 <= d1; d3 <= d2;
      dalarm <= (lamps == 3'b100 && d1 == 3'b010 && d2 == 3'b001);
    end else begin
      dalarm <= 1'b0;
    end
  end
  assign alarm_in = force_alarm | dalarm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [2:0] dec(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int ref_alarms();
    int h1 = 0, h2 = 0, h3 = 0, n = 0;
    foreach (codes[i]) begin
      if (codes[i] == 0) begin h1 = 0; h2 = 0; h3 = 0; end
      else if (int'(codes[i]) != h1) begin
        h3 = h2; h2 = h1; h1 = int'(codes[i]);
        if (h3 == 1 && h2 == 2 && h1 == 3) n++;
      end
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic load_all();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    foreach (codes[i]) begin
      load_valid = 1'b1; load_code = codes[i];
      @(negedge clk); chk("ld_ready", load_ready, 1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    @(negedge clk); chk("seq_len", seq_len, codes.size());
  endtask

  // ab/rs: cycle after start (1-based) in which abort/reset is asserted, 0 = none.
  task automatic play(input int d, input int ab, input int rs, input int extra, input int expa);
    int de, n, c;
    exp_t e;
    if (extra >= 0) codes.push_back(2'(extra));
    n = codes.size();
    de = (d == 0) ? 1 : d;
    exp_q.delete();
    for (int k = 1; k <= n*de + 2; k++) begin
      if ((ab > 0 && k > ab) || (rs > 0 && k > rs)) begin
        e = '{3'b000, 1'b0, 1'b0}; exp_q.push_back(e); break;
      end
      if (k <= n*de)       e = '{dec(codes[(k-1)/de]), 1'b1, 1'b0};
      else if (k == n*de+1) e = '{3'b000, 1'b0, 1'b1};
      else                 e = '{3'b000, 1'b0, 1'b0};
      exp_q.push_back(e);
    end
    dwell = DWELL_W'(d);
    @(posedge clk); #1 start = 1'b1;
    if (extra >= 0) begin load_valid = 1'b1; load_code = 2'(extra); end
    @(posedge clk); #1 start = 1'b0; load_valid = 1'b0;
    c = 1;
    while (exp_q.size() > 0) begin
      abort = (c == ab);
      reset = (c == rs);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("lamps", lamps, e.lamps);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      if (c == 1) chk("acnt_start", alarm_count, 0);
      @(posedge clk); #1;
      c++;
    end
    abort = 1'b0; reset = 1'b0;
    if (expa < 0) expa = ref_alarms();
    acnt_exp = expa;
    chk("alarm_count", alarm_count, expa);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_code = '0; clear = 1'b0;
    dwell = '0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_lamps", lamps, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acnt", alarm_count, 0);
    chk("rst_len", seq_len, 0);
    chk("rst_ready", load_ready, 1);

    // basic 1,2,3 at dwell 1
    codes = '{2'd1, 2'd2, 2'd3};
    load_all();
    play(1, 0, 0, -1, -1);
    chk("t1_alarm_one", alarm_count, 1);

    // start on empty buffer is ignored and keeps the count
    codes.delete();
    load_all();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("empty_busy", busy, 0);
      chk("empty_lamps", lamps, 0);
      chk("empty_done", done, 0);
      chk("empty_acnt", alarm_count, acnt_exp);
    end

    // dwell 0 behaves as 1
    codes = '{2'd1, 2'd2};
    load_all();
    play(0, 0, 0, -1, -1);

    // 15-code example at dwell 2
    codes = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3,
              2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    load_all();
    play(2, 0, 0, -1, -1);

    // full buffer, dropped 17th load, then clear
    codes.delete();
    for (int i = 0; i < DEPTH; i++) codes.push_back(2'($urandom_range(1, 3)));
    load_all();
    chk("full_ready", load_ready, 0);
    @(posedge clk); #1 load_valid = 1'b1; load_code = 2'd0;
    @(posedge clk); #1 load_valid = 1'b0;
    @(negedge clk); chk("full_len", seq_len, DEPTH);
    play(1, 0, 0, -1, -1);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_len", seq_len, 0);
    chk("clr_ready", load_ready, 1);

    // load in the start cycle joins the playback
    codes = '{2'd1, 2'd2};
    load_all();
    play(1, 0, 0, 3, -1);

    // clear beats start in the same cycle
    codes = '{2'd1};
    load_all();
    @(posedge clk); #1 start = 1'b1; clear = 1'b1;
    @(posedge clk); #1 start = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("sc_busy", busy, 0);
    chk("sc_len", seq_len, 0);

    // abort mid-playback
    codes = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    load_all();
    play(3, 5, 0, -1, 0);
    @(negedge clk); chk("ab_len", seq_len, 6);

    // reset mid-playback
    play(3, 0, 5, -1, 0);
    @(negedge clk);
    chk("rs_len", seq_len, 0);
    chk("rs_ready", load_ready, 1);

    // alarm saturation, then restart clears the count
    codes = '{2'd1, 2'd2};
    load_all();
    force_alarm = 1'b1;
    play(150, 0, 0, -1, 255);
    force_alarm = 1'b0;
    play(1, 0, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
